cc_cond_unit: RTL and testbench
===============================

Name: cc_cond_unit

Overview:
- Condition-code register and branch/move condition evaluator for the SEQ execute stage.
- Sits directly downstream of the ALU (add/sub/and/xor function blocks). Consumes the ALU operands and result, and derives and registers ZF/SF/OF on OPq instructions.
- Drives Cnd for cmovXX/jXX from the currently held flags; Cnd feeds the writeback and PC-update logic.

Parameters:
- WIDTH, 64, datapath width of ALU operands and result.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- icode  input  4  instruction code of the instruction in execute
- ifun  input  4  function code of the instruction in execute
- alu_a  input  WIDTH  ALU operand valA (signed)
- alu_b  input  WIDTH  ALU operand valB (signed)
- alu_result  input  WIDTH  ALU output valE (signed)
- stall  input  1  when 1, CC holds regardless of icode
- zf  output  1  registered zero flag
- sf  output  1  registered sign flag
- of  output  1  registered overflow flag
- cnd  output  1  condition result for cmovXX/jXX (combinational from registered flags)
- ifun_err  output  1  registered sticky error: OPq seen with ifun>3, or cmov/jxx with ifun>6

Behaviour:
- Reset (rst_n=0, asynchronous): zf=1, sf=0, of=0, ifun_err=0. All take effect immediately, independent of clk.
  - Reset deasserted mid-instruction: no update on that edge unless rst_n is already 1 at the edge.
- Arithmetic: valE = valB OP valA. ALU op by ifun: 0 add, 1 sub (valB-valA), 2 and, 3 xor.
- Flag computation (combinational, next-state):
  - zf_n = (alu_result == 0).
  - sf_n = alu_result[WIDTH-1].
  - of_n for add (ifun 0): (a_msb == b_msb) && (r_msb != a_msb).
  - of_n for sub (ifun 1): (a_msb != b_msb) && (r_msb != b_msb).
  - of_n for and/xor (ifun 2,3): 0.
- set_cc = (icode==4'h6) && (ifun<=3) && !stall && rst_n.
  - On rising clk edge with set_cc=1: zf/sf/of <= next-state values.
  - Otherwise: hold.
- Latency: flags written at end of the OPq cycle and visible from the next cycle. This matches SEQ semantics: a cmov/jxx in the same cycle as an OPq uses the old flags.
- cnd is combinational from the registered zf/sf/of, valid only when icode==4'h2 (cmovXX) or icode==4'h7 (jXX); otherwise cnd=0. Decode by ifun:
  - 0: 1 (always)
  - 1: (sf^of)|zf (le)
  - 2: sf^of (l)
  - 3: zf (e)
  - 4: !zf (ne)
  - 5: !(sf^of) (ge)
  - 6: !(sf^of)&!zf (g)
  - 7–15: 0
- ifun_err: set on a clk edge when !stall and either
  - icode==6 with ifun>3, or
  - icode in {2,7} with ifun>6.
  - Once set, clears only on reset. An invalid OPq ifun never modifies the flags.
- Simultaneous stall=1 with OPq: no flag update and no ifun_err set.
- No X propagation: with rst_n=0, all outputs are defined regardless of the other inputs.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle -> zf=1, sf=0, of=0, ifun_err=0 immediately. Then icode=7, ifun=3 -> cnd=1.
2. Add overflow: icode=6, ifun=0, a=64'h7FFF_FFFF_FFFF_FFFF, b=1, result=64'h8000_0000_0000_0000 -> after edge zf=0, sf=1, of=1. Then icode=7, ifun=2 (jl) -> cnd=0; ifun=1 (jle) -> cnd=0.
3. Sub zero: icode=6, ifun=1, a=10, b=10, result=0 -> zf=1, sf=0, of=0. Same-cycle icode=7, ifun=3 still sees the prior flags; next cycle cnd=1.
4. Xor: icode=6, ifun=3, a=-332055, b=831931, result=a^b (negative) -> sf=1, of=0, zf=0. Then cmovg (icode=2, ifun=6) -> cnd=0; cmovl (ifun=2) -> cnd=1.
5. Stall and non-OPq: stall=1 with OPq result=0 -> flags unchanged. icode=3 with any result -> flags unchanged.
6. Error: icode=6, ifun=5 -> flags unchanged, ifun_err=1 after edge and still 1 after 3 further valid cycles. Then rst_n=0 -> ifun_err=0.

Source files
------------

// File: rtl/cc_cond_unit.sv
// Condition-code register and cmovXX/jXX condition evaluator for the SEQ
// execute stage. Flags are derived from the ALU operands/result on OPq and
// registered; cnd is decoded combinationally from the registered flags, so an
// instruction in the same cycle as an OPq still observes the previous flags.
module cc_cond_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             stall,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cnd,
    output logic             ifun_err
);

    // Instruction codes that interact with the condition codes.
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;

    // OPq function codes.
    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_AND = 4'h2;
    localparam logic [3:0] FN_XOR = 4'h3;

    // Branch / move condition function codes.
    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    logic zf_q, sf_q, of_q, err_q;
    logic zf_d, sf_d, of_d, err_d;

    logic is_opq, is_cond;
    logic opq_fn_ok, cond_fn_ok;
    logic set_cc, err_set;
    logic a_msb, b_msb, r_msb;
    logic zf_n, sf_n, of_n;
    logic lt;

    // Instruction classification and update enables.
    always_comb begin
        is_opq     = (icode == ICODE_OPQ);
        is_cond    = (icode == ICODE_CMOVXX) || (icode == ICODE_JXX);
        opq_fn_ok  = (ifun <= FN_XOR);
        cond_fn_ok = (ifun <= C_G);
        // rst_n is redundant with the async reset but keeps set_cc low in reset.
        set_cc     = is_opq && opq_fn_ok && !stall && rst_n;
        err_set    = !stall && ((is_opq && !opq_fn_ok) || (is_cond && !cond_fn_ok));
    end

    // Candidate flag values from the ALU operands and result.
    always_comb begin
        a_msb = alu_a[WIDTH-1];
        b_msb = alu_b[WIDTH-1];
        r_msb = alu_result[WIDTH-1];
        zf_n  = (alu_result == '0);
        sf_n  = r_msb;
        of_n  = 1'b0;
        unique case (ifun)
            // valE = valB + valA: overflow when like-signed inputs flip sign.
            FN_ADD:  of_n = (a_msb == b_msb) && (r_msb != a_msb);
            // valE = valB - valA: overflow when unlike-signed and result leaves valB's sign.
            FN_SUB:  of_n = (a_msb != b_msb) && (r_msb != b_msb);
            FN_AND:  of_n = 1'b0;
            FN_XOR:  of_n = 1'b0;
            default: of_n = 1'b0;
        endcase
    end

    // Next-state for the flag register and sticky error.
    always_comb begin
        zf_d  = zf_q;
        sf_d  = sf_q;
        of_d  = of_q;
        err_d = err_q;
        if (set_cc) begin
            zf_d = zf_n;
            sf_d = sf_n;
            of_d = of_n;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // Flag and error state; reset leaves zf=1 so "je" is taken out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q  <= 1'b1;
            sf_q  <= 1'b0;
            of_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            zf_q  <= zf_d;
            sf_q  <= sf_d;
            of_q  <= of_d;
            err_q <= err_d;
        end
    end

    // Condition decode from the registered flags only.
    always_comb begin
        lt  = sf_q ^ of_q;
        cnd = 1'b0;
        if (is_cond) begin
            unique case (ifun)
                C_ALWAYS: cnd = 1'b1;
                C_LE:     cnd = lt | zf_q;
                C_L:      cnd = lt;
                C_E:      cnd = zf_q;
                C_NE:     cnd = !zf_q;
                C_GE:     cnd = !lt;
                C_G:      cnd = !lt && !zf_q;
                default:  cnd = 1'b0;
            endcase
        end
    end

    assign zf       = zf_q;
    assign sf       = sf_q;
    assign of       = of_q;
    assign ifun_err = err_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Scoreboard bench for cc_cond_unit: a driver issues one instruction per cycle
// and queues the expected outputs from a behavioural model; a monitor pops and
// compares on every falling edge.
module tb_cc_cond_unit;

    localparam int W = 64;
    localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] SMIN = 65'sh1_8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    icode = 4'h0;
    logic [3:0]    ifun = 4'h0;
    logic [W-1:0]  alu_a = '0;
    logic [W-1:0]  alu_b = '0;
    logic [W-1:0]  alu_result = '0;
    logic          stall = 1'b0;
    logic          zf, sf, of, cnd, ifun_err;

    cc_cond_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .icode      (icode),
        .ifun       (ifun),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .stall      (stall),
        .zf         (zf),
        .sf         (sf),
        .of         (of),
        .cnd        (cnd),
        .ifun_err   (ifun_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic zf, sf, of, cnd, err;
        int   id;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tx_id    = 0;

    // Architectural state of the reference model.
    logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0, m_err = 1'b0;

    function automatic logic [63:0] alu(input logic [3:0] fn, input logic [63:0] a,
                                        input logic [63:0] b);
        case (fn)
            4'd0:    return b + a;
            4'd1:    return b - a;
            4'd2:    return b & a;
            4'd3:    return b ^ a;
            default: return b + a;
        endcase
    endfunction

    // Overflow = true signed result does not fit in 64 bits.
    function automatic logic overflow(input logic [3:0] fn, input logic [63:0] a,
                                      input logic [63:0] b);
        logic signed [64:0] sa, sb, s;
        sa = $signed({a[63], a});
        sb = $signed({b[63], b});
        if (fn == 4'd0) s = sb + sa;
        else if (fn == 4'd1) s = sb - sa;
        else return 1'b0;
        return (s > SMAX) || (s < SMIN);
    endfunction

    function automatic logic cond_model(input logic [3:0] ic, input logic [3:0] fn);
        logic less;
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        less = (m_sf != m_of);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || m_zf;
            4'd2:    return less;
            4'd3:    return m_zf;
            4'd4:    return !m_zf;
            4'd5:    return !less;
            4'd6:    return !less && !m_zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic act, input logic exp, input int id);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s tx=%0d got=%b expected=%b", name, id, act, exp);
        end
    endtask

    // Issue one instruction mid-cycle; queue what should be visible before the next edge.
    task automatic drive(input logic r, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input logic st);
        exp_t e;
        @(posedge clk);
        #2;
        rst_n = r; icode = ic; ifun = fn; alu_a = a; alu_b = b; alu_result = res; stall = st;
        if (!r) begin
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_err = 1'b0;
        end
        e.zf = m_zf; e.sf = m_sf; e.of = m_of; e.err = m_err;
        e.cnd = cond_model(ic, fn);
        e.id = tx_id++;
        q.push_back(e);
        // State that the coming edge produces.
        if (r && !st) begin
            if (ic == 4'h6 && fn <= 4'd3) begin
                m_zf = (res == 64'd0);
                m_sf = res[63];
                m_of = overflow(fn, a, b);
            end
            if ((ic == 4'h6 && fn > 4'd3) || ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6))
                m_err = 1'b1;
        end
    endtask

    task automatic op(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic st);
        drive(1'b1, ic, fn, a, b, alu(fn, a, b), st);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 64'h7FFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'd0;
            3:       return 64'(int'($urandom_range(0, 20)) - 10);
            4:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Monitor: compare every queued expectation against the DUT on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("zf", zf, e.zf, e.id);
            check("sf", sf, e.sf, e.id);
            check("of", of, e.of, e.id);
            check("cnd", cnd, e.cnd, e.id);
            check("ifun_err", ifun_err, e.err, e.id);
        end
    end

    initial begin
        logic [63:0] a, b, res;
        logic [3:0]  ic, fn;
        logic        r, st;
        int          k;

        // Reset at time zero; je is taken from reset flags.
        drive(1'b0, 4'h7, 4'h3, '0, '0, '0, 1'b0);
        op(4'h7, 4'h3, '0, '0, 1'b0);
        // Disturb flags, then reset mid-cycle: must clear before the next edge.
        op(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        op(4'h6, 4'h5, '0, '0, 1'b0);
        drive(1'b0, 4'h7, 4'h3, '0, '0, '0, 1'b0);

        // Add overflow, then jl / jle.
        op(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        op(4'h7, 4'h2, '0, '0, 1'b0);
        op(4'h7, 4'h1, '0, '0, 1'b0);

        // Sub to zero; the next je sees the new flags.
        op(4'h6, 4'h1, 64'd10, 64'd10, 1'b0);
        op(4'h7, 4'h3, '0, '0, 1'b0);

        // Xor with negative result, then cmovg / cmovl.
        op(4'h6, 4'h3, 64'(-64'sd332055), 64'd831931, 1'b0);
        op(4'h2, 4'h6, '0, '0, 1'b0);
        op(4'h2, 4'h2, '0, '0, 1'b0);

        // Stalled OPq and non-OPq leave flags alone; stalled bad ifun sets no error.
        op(4'h6, 4'h1, 64'd5, 64'd5, 1'b1);
        op(4'h6, 4'h7, 64'd5, 64'd5, 1'b1);
        drive(1'b1, 4'h3, 4'h0, 64'd3, 64'd3, 64'd0, 1'b0);
        op(4'h7, 4'h3, '0, '0, 1'b0);

        // Invalid OPq ifun: sticky error, flags unchanged, cleared only by reset.
        op(4'h6, 4'h5, 64'd7, 64'd7, 1'b0);
        op(4'h6, 4'h0, 64'd1, 64'd2, 1'b0);
        op(4'h6, 4'h1, 64'd2, 64'd2, 1'b0);
        op(4'h7, 4'h0, '0, '0, 1'b0);
        op(4'h2, 4'h9, '0, '0, 1'b0);
        drive(1'b0, 4'h2, 4'h9, '0, '0, '0, 1'b0);
        op(4'h7, 4'h9, '0, '0, 1'b0);
        drive(1'b0, 4'h0, 4'h0, '0, '0, '0, 1'b0);

        // Randomised mix.
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            k = $urandom_range(0, 9);
            if (k < 4) ic = 4'h6;
            else if (k < 6) ic = 4'h7;
            else if (k < 8) ic = 4'h2;
            else if (k == 8) ic = 4'h3;
            else ic = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) fn = 4'($urandom_range(0, 15));
            else if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
            else fn = 4'($urandom_range(0, 6));
            a = rand_operand();
            b = ($urandom_range(0, 3) == 0) ? a : rand_operand();
            st = ($urandom_range(0, 7) == 0);
            res = (ic == 4'h6) ? alu(fn, a, b) : {$urandom(), $urandom()};
            drive(r, ic, fn, a, b, res, st);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
